muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit. It replaces the fixed 32-bit divider feeding the execute-stage HI/LO path and adds multiply, divide-by-zero detection and a busy flag for stall generation. It is a radix-2 sequential engine with a start/annul/ready handshake. It sits beside the ALU in EX: the ALU drives `start_i` while it holds the pipeline stalled, and `result_o` is written to HI/LO.

---
 rtl/muldiv_iter.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply/divide unit for the EX-stage HI/LO path.
// Latency: WIDTH+1 edges from accept to the ready_o cycle; divide-by-zero is reported one edge after accept.
// Backpressure: start_i is honoured only in IDLE (busy_o low); requests made while busy are dropped, not queued.
//
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   start_i, annul_i      request / abort of an in-flight calculation
//   op_i                  00 mult, 01 multu, 10 div, 11 divu
//   opa_i, opb_i          operands, sampled on the accept edge only
//   result_o              product, or {remainder, quotient}; holds until the next completion
//   ready_o, divzero_o    one-cycle completion pulse and its divide-by-zero qualifier
//   busy_o                operation in flight (stall request)

module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               divzero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ZERO,
    S_DONE
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [1:0]         op_q,      op_d;
  logic               neg_a_q,   neg_a_d;
  logic               neg_b_q,   neg_b_d;
  // Addend for multiply, divisor for divide (always a magnitude).
  logic [WIDTH-1:0]   opnd_q,    opnd_d;
  // hi: running partial sum (mult) or partial remainder (div), one guard bit.
  // lo: multiplier shifting out / product low half (mult) or dividend shifting
  //     out / quotient shifting in (div). In ZERO it holds the raw dividend.
  logic [WIDTH:0]     hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic [2*WIDTH-1:0] result_q,  result_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;
  logic               divzero_q, divzero_d;

  // Operand preparation on the accept edge.
  logic               in_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  // Iteration datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic               last_iter;

  // Sign correction at completion.
  logic               sgn_op;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  always_comb begin
    in_signed = ~op_i[0];
    in_neg_a  = in_signed & opa_i[WIDTH-1];
    in_neg_b  = in_signed & opb_i[WIDTH-1];
    // The most-negative value negates to itself, which read unsigned is the
    // correct magnitude 2^(WIDTH-1).
    in_mag_a  = in_neg_a ? -opa_i : opa_i;
    in_mag_b  = in_neg_b ? -opb_i : opb_i;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole {hi, lo} pair right by one.
    mul_sum   = hi_q + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};

    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor only if it fits.
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_sub   = div_shift - {1'b0, opnd_q};

    last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    sgn_op    = ~op_q[0];
    prod_raw  = {hi_q[WIDTH-1:0], lo_q};
    prod_fix  = (sgn_op & (neg_a_q ^ neg_b_q)) ? -prod_raw : prod_raw;
    rem_raw   = hi_q[WIDTH-1:0];
    // Remainder follows the dividend's sign (truncating division).
    rem_fix   = (sgn_op & neg_a_q) ? -rem_raw : rem_raw;
    quo_fix   = (sgn_op & (neg_a_q ^ neg_b_q)) ? -lo_q : lo_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    busy_d    = 1'b0;
    divzero_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          op_d    = op_i;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (op_i[1] && (opb_i == '0)) begin
            state_d = S_ZERO;
            lo_d    = opa_i;
          end else begin
            state_d = S_CALC;
            hi_d    = '0;
            opnd_d  = op_i[1] ? in_mag_b : in_mag_a;
            lo_d    = op_i[1] ? in_mag_a : in_mag_b;
          end
        end
      end

      S_CALC: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
          if (op_q[1]) begin
            hi_d = div_ge ? div_sub : div_shift;
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_d = {1'b0, mul_sum[WIDTH:1]};
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_d = S_DONE;
          end
        end
      end

      S_ZERO: begin
        result_d  = {lo_q, {WIDTH{1'b1}}};
        ready_d   = 1'b1;
        divzero_d = 1'b1;
        state_d   = S_IDLE;
      end

      S_DONE: begin
        result_d = op_q[1] ? {rem_fix, quo_fix} : prod_fix;
        ready_d  = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      divzero_q <= divzero_d;
    end
  end

  assign result_o  = result_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign divzero_o = divzero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: exercises a 32-bit and an 8-bit muldiv_iter against an
// arithmetic reference model with directed plan cases and random traffic.
// Outputs are compared on every falling edge.

module tb_muldiv_iter;

  logic        clk;
  logic        rst   [2];
  logic        start [2];
  logic        annul [2];
  logic [1:0]  op    [2];
  logic [31:0] opa   [2];
  logic [31:0] opb   [2];

  logic [63:0] res32;
  logic [15:0] res8;
  logic        rdy0, rdy1, busy0, busy1, dz0, dz1;

  logic [63:0] res_w  [2];
  logic        rdy_w  [2];
  logic        busy_w [2];
  logic        dz_w   [2];

  int checks;
  int errors;
  bit chk_en;

  muldiv_iter #(.WIDTH(32)) u_w32 (
    .clk(clk), .reset(rst[0]), .start_i(start[0]), .annul_i(annul[0]),
    .op_i(op[0]), .opa_i(opa[0]), .opb_i(opb[0]),
    .result_o(res32), .ready_o(rdy0), .busy_o(busy0), .divzero_o(dz0)
  );

  muldiv_iter #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(rst[1]), .start_i(start[1]), .annul_i(annul[1]),
    .op_i(op[1]), .opa_i(opa[1][7:0]), .opb_i(opb[1][7:0]),
    .result_o(res8), .ready_o(rdy1), .busy_o(busy1), .divzero_o(dz1)
  );

  assign res_w[0]  = res32;
  assign res_w[1]  = {48'd0, res8};
  assign rdy_w[0]  = rdy0;
  assign rdy_w[1]  = rdy1;
  assign busy_w[0] = busy0;
  assign busy_w[1] = busy1;
  assign dz_w[0]   = dz0;
  assign dz_w[1]   = dz1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: results of a w-bit operation from integer math.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input int w, output bit dz);
    longint unsigned m, m2, ua, ub, res;
    longint sa, sb, q, r;
    m  = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = ua[w-1] ? (signed'(ua) - signed'(64'd1 << w)) : signed'(ua);
    sb = ub[w-1] ? (signed'(ub) - signed'(64'd1 << w)) : signed'(ub);
    dz = 1'b0;
    res = 64'd0;
    case (o)
      2'd0: res = unsigned'(sa * sb) & m2;
      2'd1: res = (ua * ub) & m2;
      2'd2: begin
        if (ub == 0) begin
          dz = 1'b1; res = (ua << w) | m;
        end else begin
          q = sa / sb; r = sa % sb;
          res = ((unsigned'(r) & m) << w) | (unsigned'(q) & m);
        end
      end
      default: begin
        if (ub == 0) begin
          dz = 1'b1; res = (ua << w) | m;
        end else begin
          res = ((ua % ub) << w) | (ua / ub);
        end
      end
    endcase
    return res;
  endfunction

  // Cycle-level expectation: an accepted op stays busy for a fixed number of
  // edges, then reports once; annul cuts it short only while still computing.
  bit          pend     [2];
  int          left     [2];
  bit          dzp      [2];
  logic [63:0] stash    [2];
  logic [63:0] exp_res  [2];
  bit          exp_rdy  [2];
  bit          exp_busy [2];
  bit          exp_dz   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        pend[i] = 0; exp_rdy[i] = 0; exp_busy[i] = 0; exp_dz[i] = 0;
        exp_res[i] = '0;
      end else begin
        exp_rdy[i] = 0;
        exp_dz[i]  = 0;
        if (pend[i]) begin
          if (annul[i] && !dzp[i] && left[i] >= 2) begin
            pend[i] = 0;
          end else begin
            left[i]--;
            if (left[i] == 0) begin
              pend[i] = 0; exp_rdy[i] = 1; exp_dz[i] = dzp[i];
              exp_res[i] = stash[i];
            end
          end
        end else if (start[i] && !annul[i]) begin
          bit dzt;
          stash[i] = model(op[i], opa[i], opb[i], w_of(i), dzt);
          dzp[i]   = dzt;
          pend[i]  = 1;
          left[i]  = dzt ? 1 : w_of(i) + 1;
        end
        exp_busy[i] = pend[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check(i == 0 ? "w32_ready"  : "w8_ready",   {63'd0, rdy_w[i]},  {63'd0, exp_rdy[i]});
        check(i == 0 ? "w32_busy"   : "w8_busy",    {63'd0, busy_w[i]}, {63'd0, exp_busy[i]});
        check(i == 0 ? "w32_divz"   : "w8_divz",    {63'd0, dz_w[i]},   {63'd0, exp_dz[i]});
        check(i == 0 ? "w32_result" : "w8_result",  res_w[i],           exp_res[i]);
      end
    end
  end

  // Issue one request at a falling edge; optional annul / stray start / reset
  // at a given number of edges after the accept. lat = edges to ready, or -1.
  task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int annul_at, input int pulse_at,
                        input int rst_at, output int lat, output logic [63:0] r,
                        output logic d);
    int guard;
    lat = -1; r = '0; d = 1'b0;
    guard = 0;
    while (pend[i] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (pend[i]) begin
      errors++; checks++;
      $display("FAIL idle_wait: unit %0d still busy after %0d cycles", i, guard);
    end
    start[i] = 1'b1; op[i] = o; opa[i] = a; opb[i] = b;
    @(negedge clk);
    start[i] = 1'b0; opa[i] = $urandom; opb[i] = $urandom; op[i] = 2'($urandom);
    for (int c = 1; c <= w_of(i) + 12; c++) begin
      @(negedge clk);
      if (rdy_w[i]) begin
        lat = c; r = res_w[i]; d = dz_w[i];
        break;
      end
      if (annul_at > 0 && c == annul_at + 1)
        check("annul_busy", {63'd0, busy_w[i]}, 64'd0);
      if (rst_at > 0 && c == rst_at + 1) begin
        check("rst_result", res_w[i], 64'd0);
        check("rst_busy", {63'd0, busy_w[i]}, 64'd0);
        check("rst_ready", {63'd0, rdy_w[i]}, 64'd0);
      end
      annul[i] = (c == annul_at);
      start[i] = (c == pulse_at);
      rst[i]   = (c == rst_at);
    end
    annul[i] = 1'b0; start[i] = 1'b0; rst[i] = 1'b0;
  endtask

  task automatic expect_op(input string name, input int i, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_r, input logic exp_d, input int exp_lat);
    int lat; logic [63:0] r; logic d;
    run_op(i, o, a, b, -1, -1, -1, lat, r, d);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, r, exp_r);
    check({name, "_dz"}, {63'd0, d}, {63'd0, exp_d});
  endtask

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] one;
    one = 32'd1;
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return one << (w - 1);
      4: return (one << (w - 1)) - 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat; logic [63:0] r; logic d; bit dzt;
    checks = 0; errors = 0; chk_en = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; annul[i] = 1'b0;
      op[i] = 2'd0; opa[i] = '0; opb[i] = '0;
    end

    // Model pinned to hand-computed values.
    check("pin_divu",  model(2'd3, 32'd100, 32'd7, 32, dzt), 64'h00000002_0000000E);
    check("pin_div",   model(2'd2, 32'hFFFFFFF9, 32'd2, 32, dzt), 64'hFFFFFFFF_FFFFFFFD);
    check("pin_ovf",   model(2'd2, 32'h80000000, 32'hFFFFFFFF, 32, dzt), 64'h00000000_80000000);
    check("pin_mult",  model(2'd0, 32'hFFFFFFFF, 32'd2, 32, dzt), 64'hFFFFFFFF_FFFFFFFE);
    check("pin_multu", model(2'd1, 32'hFFFFFFFF, 32'd2, 32, dzt), 64'h00000001_FFFFFFFE);
    check("pin_w8",    model(2'd3, 32'd200, 32'd9, 8, dzt), 64'h0000_0000_0000_0216);
    check("pin_dz",    model(2'd3, 32'h1234, 32'd0, 32, dzt), 64'h00001234_FFFFFFFF);
    check("pin_dzflag", {63'd0, dzt}, 64'd1);

    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_res",  res_w[0], 64'd0);
    check("reset_busy", {63'd0, busy_w[0]}, 64'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // Directed plan cases on the 32-bit unit.
    expect_op("divu_100_7", 0, 2'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);
    expect_op("div_m7_2",   0, 2'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33);
    expect_op("div_ovf",    0, 2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33);
    expect_op("mult",       0, 2'd0, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 33);
    expect_op("multu",      0, 2'd1, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 1'b0, 33);
    expect_op("divu_zero",  0, 2'd3, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF, 1'b1, 1);
    expect_op("divu_9_3",   0, 2'd3, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, 33);

    // Annul at iteration 10: no completion, result unchanged.
    run_op(0, 2'd1, 32'd3, 32'd5, 10, -1, -1, lat, r, d);
    check("annul_noready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    check("annul_hold", res_w[0], 64'h00000000_00000003);

    // start together with annul in IDLE is not accepted.
    start[0] = 1'b1; annul[0] = 1'b1; op[0] = 2'd1; opa[0] = 32'd4; opb[0] = 32'd4;
    @(negedge clk);
    start[0] = 1'b0; annul[0] = 1'b0;
    check("start_annul_busy", {63'd0, busy_w[0]}, 64'd0);

    // Stray start mid-calculation is ignored.
    run_op(0, 2'd3, 32'd100, 32'd7, -1, 6, -1, lat, r, d);
    check("stray_lat", 64'(lat), 64'd33);
    check("stray_res", r, 64'h00000002_0000000E);

    // Reset at iteration 5, then a clean divide.
    run_op(0, 2'd0, 32'd77, 32'd99, -1, -1, 5, lat, r, d);
    check("rst_noready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    expect_op("post_rst", 0, 2'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);

    // 8-bit unit.
    expect_op("w8_divu", 1, 2'd3, 32'd200, 32'd9, 64'h0000_0000_0000_0216, 1'b0, 9);
    expect_op("w8_div",  1, 2'd2, 32'h80, 32'hFF, 64'h0000_0000_0000_0080, 1'b0, 9);

    // Random traffic, back-to-back, occasional annul.
    for (int n = 0; n < 150; n++) begin
      int an;
      an = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : -1;
      run_op(0, 2'($urandom_range(0, 3)), rnd(32), rnd(32), an, -1, -1, lat, r, d);
    end
    for (int n = 0; n < 120; n++) begin
      int an;
      an = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 9)) : -1;
      run_op(1, 2'($urandom_range(0, 3)), rnd(8), rnd(8), an, -1, -1, lat, r, d);
    end

    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
